// File: rtl/frame_buffer_manager.sv
// N-buffer swap controller between a frame producer and the VGA scan-out.
// Tracks buffer ownership, grants free back buffers, and swaps the displayed buffer.
module frame_buffer_manager #(
    parameter int NUM_BUFFERS = 3,
    parameter int IDX_W       = $clog2(NUM_BUFFERS),
    parameter int CNT_W       = 16,
    parameter int SWAP_MODE   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             refresh,
    input  logic             draw_req,
    input  logic             draw_done,
    output logic             draw_grant,
    output logic [IDX_W-1:0] draw_idx,
    output logic [IDX_W-1:0] display_idx,
    output logic             swap_pulse,
    output logic             ready_valid,
    output logic [CNT_W-1:0] dropped_count,
    output logic [CNT_W-1:0] repeat_count
);

    typedef enum logic {S_IDLE, S_DRAWING} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] display_q, display_d;
    logic [IDX_W-1:0] ready_q, ready_d;
    logic [IDX_W-1:0] draw_idx_q, draw_idx_d;
    logic             ready_valid_q, ready_valid_d;
    logic             swap_evt_q, swap_evt_d;
    logic             swap_pulse_q, swap_pulse_d;
    logic             done_seen_q, done_seen_d;
    logic [CNT_W-1:0] dropped_q, dropped_d;
    logic [CNT_W-1:0] repeat_q, repeat_d;
    logic [IDX_W-1:0] free_idx;
    logic             free_found;
    logic             done_ev;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Descending scan so the lowest eligible index wins.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_BUFFERS - 1; i >= 0; i--) begin
            if (IDX_W'(i) != display_q &&
                !(ready_valid_q && IDX_W'(i) == ready_q) &&
                !(draw_grant && IDX_W'(i) == draw_idx_q)) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (draw_req && free_found) state_d = S_DRAWING;
            S_DRAWING: if (draw_done)              state_d = S_IDLE;
            default:                               state_d = S_IDLE;
        endcase
    end

    always_comb begin
        draw_grant = (state_q == S_DRAWING);
        done_ev    = draw_grant && draw_done;
    end

    always_comb begin
        display_d     = display_q;
        ready_d       = ready_q;
        ready_valid_d = ready_valid_q;
        draw_idx_d    = draw_idx_q;
        dropped_d     = dropped_q;
        repeat_d      = repeat_q;
        done_seen_d   = done_seen_q;
        swap_evt_d    = 1'b0;
        swap_pulse_d  = swap_evt_q;

        if (state_q == S_IDLE && draw_req && free_found)
            draw_idx_d = free_idx;

        if (SWAP_MODE == 0) begin
            // Swap decisions use the ready state from before this cycle's draw_done.
            if (refresh) begin
                if (ready_valid_q) begin
                    display_d     = ready_q;
                    ready_valid_d = 1'b0;
                    swap_evt_d    = 1'b1;
                end else begin
                    repeat_d = sat_inc(repeat_q);
                end
            end
            if (done_ev) begin
                if (ready_valid_q && !refresh)
                    dropped_d = sat_inc(dropped_q);
                ready_d       = draw_idx_q;
                ready_valid_d = 1'b1;
            end
        end else begin
            if (done_ev) begin
                display_d   = draw_idx_q;
                swap_evt_d  = 1'b1;
                done_seen_d = 1'b1;
            end
            if (refresh) begin
                if (!done_seen_q && !done_ev)
                    repeat_d = sat_inc(repeat_q);
                done_seen_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            display_q     <= '0;
            ready_q       <= '0;
            ready_valid_q <= 1'b0;
            draw_idx_q    <= '0;
            dropped_q     <= '0;
            repeat_q      <= '0;
            done_seen_q   <= 1'b0;
            swap_evt_q    <= 1'b0;
            swap_pulse_q  <= 1'b0;
        end else begin
            display_q     <= display_d;
            ready_q       <= ready_d;
            ready_valid_q <= ready_valid_d;
            draw_idx_q    <= draw_idx_d;
            dropped_q     <= dropped_d;
            repeat_q      <= repeat_d;
            done_seen_q   <= done_seen_d;
            swap_evt_q    <= swap_evt_d;
            swap_pulse_q  <= swap_pulse_d;
        end
    end

    assign draw_idx      = draw_idx_q;
    assign display_idx   = display_q;
    assign swap_pulse    = swap_pulse_q;
    assign ready_valid   = ready_valid_q;
    assign dropped_count = dropped_q;
    assign repeat_count  = repeat_q;

endmodule

// File: tb/tb_frame_buffer_manager.sv
module tb_frame_buffer_manager;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic a_rst = 1'b1, a_ref = 1'b0, a_req = 1'b0, a_done = 1'b0;
    logic a_grant, a_swap, a_rv;
    logic [1:0] a_didx, a_disp;
    logic [15:0] a_drop, a_rep;
    logic d_grant, d_swap, d_rv;
    logic [1:0] d_didx, d_disp, d_drop, d_rep;
    logic b_rst = 1'b1, b_ref = 1'b0, b_req = 1'b0, b_done = 1'b0;
    logic b_grant, b_swap, b_rv;
    logic [0:0] b_didx, b_disp;
    logic [15:0] b_drop, b_rep;
    logic c_rst = 1'b1, c_ref = 1'b0, c_req = 1'b0, c_done = 1'b0;
    logic c_grant, c_swap, c_rv;
    logic [1:0] c_didx, c_disp;
    logic [15:0] c_drop, c_rep;

    logic a_seen_swap = 1'b0;
    always @(posedge clk) if (a_swap === 1'b1) a_seen_swap <= 1'b1;

    frame_buffer_manager #(.NUM_BUFFERS(3), .CNT_W(16), .SWAP_MODE(0)) u_a (
        .clk(clk), .rst(a_rst), .refresh(a_ref), .draw_req(a_req), .draw_done(a_done),
        .draw_grant(a_grant), .draw_idx(a_didx), .display_idx(a_disp), .swap_pulse(a_swap),
        .ready_valid(a_rv), .dropped_count(a_drop), .repeat_count(a_rep));
    frame_buffer_manager #(.NUM_BUFFERS(3), .CNT_W(2), .SWAP_MODE(0)) u_d (
        .clk(clk), .rst(a_rst), .refresh(a_ref), .draw_req(a_req), .draw_done(a_done),
        .draw_grant(d_grant), .draw_idx(d_didx), .display_idx(d_disp), .swap_pulse(d_swap),
        .ready_valid(d_rv), .dropped_count(d_drop), .repeat_count(d_rep));
    frame_buffer_manager #(.NUM_BUFFERS(2), .CNT_W(16), .SWAP_MODE(0)) u_b (
        .clk(clk), .rst(b_rst), .refresh(b_ref), .draw_req(b_req), .draw_done(b_done),
        .draw_grant(b_grant), .draw_idx(b_didx), .display_idx(b_disp), .swap_pulse(b_swap),
        .ready_valid(b_rv), .dropped_count(b_drop), .repeat_count(b_rep));
    frame_buffer_manager #(.NUM_BUFFERS(3), .CNT_W(16), .SWAP_MODE(1)) u_c (
        .clk(clk), .rst(c_rst), .refresh(c_ref), .draw_req(c_req), .draw_done(c_done),
        .draw_grant(c_grant), .draw_idx(c_didx), .display_idx(c_disp), .swap_pulse(c_swap),
        .ready_valid(c_rv), .dropped_count(c_drop), .repeat_count(c_rep));

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        n_fail++;
        $error("FAIL timeout: bench did not complete within wait bound");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        tick(2);
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;

        chk("rst_disp", a_disp, 2'd0);
        chk("rst_didx", a_didx, 2'd0);
        chk("rst_grant", a_grant, 1'b0);
        chk("rst_rv", a_rv, 1'b0);
        chk("rst_swap", a_swap, 1'b0);
        chk("rst_drop", a_drop, 16'd0);
        chk("rst_rep", a_rep, 16'd0);

        for (int i = 0; i < 3; i++) begin
            a_ref = 1'b1; tick(1); a_ref = 1'b0; tick(1);
        end
        chk("rep3_disp", a_disp, 2'd0);
        chk("rep3_count", a_rep, 16'd3);
        chk("rep3_grant", a_grant, 1'b0);
        chk("rep3_noswap", a_seen_swap, 1'b0);
        chk("sat_rep3", d_rep, 2'd3);
        a_ref = 1'b1; tick(1); a_ref = 1'b0; tick(1);
        chk("rep4_count", a_rep, 16'd4);
        chk("sat_rep_hold", d_rep, 2'd3);

        a_req = 1'b1;
        chk("grant_not_yet", a_grant, 1'b0);
        tick(1);
        chk("grant_rise", a_grant, 1'b1);
        chk("grant_idx1", a_didx, 2'd1);
        a_req = 1'b0; a_done = 1'b1; tick(1); a_done = 1'b0;
        chk("done_grant0", a_grant, 1'b0);
        chk("done_rv", a_rv, 1'b1);
        a_ref = 1'b1; tick(1); a_ref = 1'b0;
        chk("swap_disp1", a_disp, 2'd1);
        chk("swap_rv0", a_rv, 1'b0);
        chk("swap_pulse_early", a_swap, 1'b0);
        tick(1);
        chk("swap_pulse_hi", a_swap, 1'b1);
        tick(1);
        chk("swap_pulse_lo", a_swap, 1'b0);
        chk("swap_rep_same", a_rep, 16'd4);

        a_rst = 1'b1; tick(1); a_rst = 1'b0;
        a_req = 1'b1; tick(1);
        chk("drop_g1", a_didx, 2'd1);
        a_req = 1'b0; a_done = 1'b1; tick(1); a_done = 1'b0;
        a_req = 1'b1; tick(1);
        chk("drop_g2", a_didx, 2'd2);
        a_req = 1'b0; a_done = 1'b1; tick(1); a_done = 1'b0;
        chk("drop_count1", a_drop, 16'd1);
        chk("drop_rv", a_rv, 1'b1);
        a_req = 1'b1; tick(1); a_req = 1'b0;
        chk("drop_reuse_grant", a_grant, 1'b1);
        chk("drop_reuse_idx1", a_didx, 2'd1);
        a_ref = 1'b1; tick(1); a_ref = 1'b0;
        chk("drop_disp2", a_disp, 2'd2);
        chk("drop_rv0", a_rv, 1'b0);

        a_rst = 1'b1; tick(1); a_rst = 1'b0;
        a_req = 1'b1; tick(1);
        a_req = 1'b0; a_done = 1'b1; tick(1); a_done = 1'b0;
        a_req = 1'b1; tick(1); a_req = 1'b0;
        chk("sim_draw2", a_didx, 2'd2);
        a_ref = 1'b1; a_done = 1'b1; tick(1); a_ref = 1'b0; a_done = 1'b0;
        chk("sim_disp1", a_disp, 2'd1);
        chk("sim_rv1", a_rv, 1'b1);
        chk("sim_drop0", a_drop, 16'd0);
        chk("sim_rep0", a_rep, 16'd0);
        chk("sim_grant0", a_grant, 1'b0);
        a_ref = 1'b1; tick(1); a_ref = 1'b0;
        chk("sim_ready2", a_disp, 2'd2);

        b_req = 1'b1; tick(1);
        chk("db_g1", b_didx, 1'd1);
        b_req = 1'b0; b_done = 1'b1; tick(1); b_done = 1'b0;
        b_req = 1'b1; tick(4);
        chk("db_blocked", b_grant, 1'b0);
        b_ref = 1'b1; tick(1); b_ref = 1'b0;
        chk("db_disp1", b_disp, 1'd1);
        tick(1);
        chk("db_grant", b_grant, 1'b1);
        chk("db_idx0", b_didx, 1'd0);
        b_req = 1'b0;

        c_req = 1'b1; tick(1); c_req = 1'b0;
        chk("im_g1", c_didx, 2'd1);
        tick(2);
        chk("im_disp_wait", c_disp, 2'd0);
        c_done = 1'b1; tick(1); c_done = 1'b0;
        chk("im_disp1", c_disp, 2'd1);
        chk("im_rv0", c_rv, 1'b0);
        tick(1);
        chk("im_pulse", c_swap, 1'b1);
        c_ref = 1'b1; tick(1); c_ref = 1'b0;
        chk("im_rep0", c_rep, 16'd0);
        c_ref = 1'b1; tick(1); c_ref = 1'b0;
        chk("im_rep1", c_rep, 16'd1);
        chk("im_drop0", c_drop, 16'd0);
        c_req = 1'b1; tick(1);
        chk("im_g0", c_didx, 2'd0);
        chk("im_grant", c_grant, 1'b1);
        c_rst = 1'b1; tick(1);
        chk("im_rst_grant", c_grant, 1'b0);
        chk("im_rst_disp", c_disp, 2'd0);
        chk("im_rst_didx", c_didx, 2'd0);
        chk("im_rst_rep", c_rep, 16'd0);
        chk("im_rst_swap", c_swap, 1'b0);
        chk("im_rst_rv", c_rv, 1'b0);
        c_rst = 1'b0; c_req = 1'b0;
        tick(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/frame_buffer_manager.md
Name: frame_buffer_manager

Overview:
- Parametrised N-buffer swap controller that replaces the fixed two-frame active_frame toggle between graphics_driver (producer) and vga_controller (consumer).
- Hands free back buffers to the producer, queues completed frames, and selects the displayed buffer at each refresh boundary.
- Counts dropped and repeated frames.
- Sits beside graphics_driver and vga_controller in main, clocked by the VGA clock.

Parameters:
- NUM_BUFFERS, 3, number of frame buffers; legal range 2..8 (2 = double buffering, 3+ = triple/multi buffering).
- IDX_W, $clog2(NUM_BUFFERS), width of buffer index ports.
- CNT_W, 16, width of statistics counters.
- SWAP_MODE, 0, 0 = swap only on refresh pulse (tear-free); 1 = swap immediately on draw_done (tearing allowed, lowest latency).

Ports:
- clk  input  1  VGA pixel-domain clock.
- rst  input  1  synchronous reset, active-high.
- refresh  input  1  one-cycle frame-boundary pulse, already synchronous to clk.
- draw_req  input  1  producer requests a back buffer; level, held until draw_grant.
- draw_done  input  1  one-cycle pulse: producer finished the granted buffer.
- draw_grant  output  1  high while the producer owns a buffer.
- draw_idx  output  IDX_W  buffer index the producer may write; valid while draw_grant.
- display_idx  output  IDX_W  buffer index vga_controller must scan out.
- swap_pulse  output  1  one-cycle pulse the cycle after display_idx changes.
- ready_valid  output  1  a completed frame is queued and not yet displayed.
- dropped_count  output  CNT_W  completed frames overwritten before display; saturating.
- repeat_count  output  CNT_W  refresh pulses with no new frame; saturating.

Behaviour:
- Reset values: display_idx=0, draw_idx=0, draw_grant=0, ready_valid=0, ready_idx=0, swap_pulse=0, both counters=0; producer FSM in IDLE. Reset mid-draw abandons the frame with no count change.
- Buffer ownership: each index is exactly one of DISPLAY, READY, DRAWING or FREE. Free search is combinational: the lowest index not equal to display_idx, not ready_idx when ready_valid, and not draw_idx when draw_grant.
- Producer FSM, state IDLE: if draw_req and a free buffer exists, go to DRAWING next cycle with draw_grant=1 and draw_idx=that buffer, registered. Grant latency is 1 cycle. With no free buffer (NUM_BUFFERS=2 and ready_valid=1), remain in IDLE and keep draw_grant=0.
- Producer FSM, state DRAWING: draw_grant is held at 1 and draw_idx is stable. On draw_done, return to IDLE with draw_grant=0 next cycle.
  - If ready_valid was already set, the old ready buffer becomes FREE and dropped_count increments.
  - ready_idx becomes draw_idx and ready_valid=1.
  - draw_done is ignored in IDLE.
- Swap, SWAP_MODE=0: on refresh with ready_valid=1, display_idx<=ready_idx and ready_valid<=0; the old display buffer becomes FREE. swap_pulse=1 on the following cycle. On refresh with ready_valid=0, display_idx is unchanged and repeat_count increments.
- Swap, SWAP_MODE=1:
  - On draw_done: display_idx<=draw_idx directly and ready_valid stays 0.
  - swap_pulse follows 1 cycle later.
  - On refresh: no swap; repeat_count increments if no draw_done occurred since the previous refresh.
  - dropped_count stays 0.
- Simultaneous refresh and draw_done (SWAP_MODE=0):
  - Swap uses the pre-cycle ready state. If ready_valid=1, the old ready buffer is displayed and the new frame becomes ready, with no drop.
  - If ready_valid=0, the result is a repeat plus the new frame becoming ready.
- Counters saturate at all-ones; no wrap.
- Invariant: display_idx, ready_idx (when valid) and draw_idx (when granted) are pairwise distinct at all times.

Test Plan:
- Reset, then 3 refresh pulses, no draws (NUM_BUFFERS=3): display_idx=0, repeat_count=3, draw_grant=0, swap_pulse never high.
- draw_req held, then draw_done, then refresh: draw_grant rises 1 cycle after req with draw_idx=1. After done, ready_valid=1. The refresh gives display_idx=1, swap_pulse 1 cycle later and ready_valid=0.
- NUM_BUFFERS=3, two frames completed (idx1, then idx2) before a refresh: dropped_count=1, buffer 1 is reused by the next grant, and the refresh displays idx2.
- NUM_BUFFERS=2, frame complete and draw_req held across 4 cycles with no refresh: draw_grant stays 0. After refresh, grant arrives with draw_idx=0 (old display).
- refresh and draw_done in the same cycle with ready_valid=1 (ready=1, drawing=2): display_idx=1, ready_idx=2, ready_valid=1, dropped_count unchanged.
- SWAP_MODE=1, draw_done on idx1 mid-frame: display_idx=1 next cycle without waiting for refresh. Then rst asserted during DRAWING: all outputs return to reset values next cycle.
